mod3_seq_monitor: RTL and testbench



---
 rtl/mod3mon_pkg.sv | 31 +++
 rtl/modn_wrap_counter.sv | 45 ++++
 rtl/mod3_seq_monitor.sv | 154 +++++++++++++++
 tb/tb_mod3_seq_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod3mon_pkg.sv
// rtl/mod3mon_pkg.sv - shared types, code constants and transition rule for the mod-3 sequence monitor
package mod3mon_pkg;

    // Monitor FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    // Upstream mod-3 counter codes
    localparam logic [1:0] C0 = 2'b00;
    localparam logic [1:0] C1 = 2'b01;
    localparam logic [1:0] C2 = 2'b10;
    localparam logic [1:0] CX = 2'b11;

    // True only for the three steps of the legal cycle 00->01->10->00.
    // A repeated code and anything touching 11 are illegal.
    function automatic logic legal_next(input logic [1:0] prev, input logic [1:0] cur);
        logic ok;
        ok = 1'b0;
        case (prev)
            C0:      ok = (cur == C1);
            C1:      ok = (cur == C2);
            C2:      ok = (cur == C0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/modn_wrap_counter.sv
// rtl/modn_wrap_counter.sv - registered modulo-MOD event counter with terminal-count pulse
//
// Ports:
//   clk  in   1   rising-edge clock
//   res  in   1   synchronous active-high reset
//   clr  in   1   synchronous clear of count (tc forced low)
//   inc  in   1   count one event
//   cnt  out  CW  current count, 0..MOD-1
//   tc   out  1   one-cycle pulse when an increment rolls MOD-1 -> 0
module modn_wrap_counter #(
    parameter int MOD = 4,
    localparam int CW = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic          tc_q;

    always_ff @(posedge clk) begin
        if (res || clr) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else if (inc) begin
            if (cnt_q == CW'(MOD - 1)) begin
                cnt_q <= '0;
                tc_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                tc_q  <= 1'b0;
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;

endmodule

// File: rtl/mod3_seq_monitor.sv
// rtl/mod3_seq_monitor.sv - lock monitor and cascaded mod-(3*MOD) timebase on a mod-3 code stream
//
// Optional feature: define MOD3MON_STICKY_ERR_EN to add err_clr/err_flag.
//
// Ports:
//   clk       in   1      rising-edge clock, shared with upstream counter
//   res       in   1      synchronous active-high reset
//   en        in   1      sample qualifier for code_in
//   code_in   in   2      upstream mod-3 code
//   locked    out  1      high while in LOCK
//   wrap      out  1      pulse on 10->00 seen while locked
//   cnt       out  CW     wrap count modulo MOD
//   tc        out  1      pulse with wrap when cnt rolls MOD-1 -> 0
//   err       out  1      pulse on illegal transition while locked
//   err_cnt   out  ERR_W  saturating err pulse count
//   err_clr   in   1      (sticky build) clears err_flag
//   err_flag  out  1      (sticky build) sticky error indicator
module mod3_seq_monitor
    import mod3mon_pkg::*;
#(
    parameter int MOD      = 4,
    parameter int LOCK_CYC = 3,
    parameter int ERR_W    = 4,
    localparam int CW      = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [1:0]       code_in,
    output logic             locked,
    output logic             wrap,
    output logic [CW-1:0]    cnt,
    output logic             tc,
    output logic             err,
`ifdef MOD3MON_STICKY_ERR_EN
    input  logic             err_clr,
    output logic             err_flag,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    // Enough bits to hold 0..LOCK_CYC-1
    localparam int AW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    state_t            state_q;
    logic [1:0]        prev_q;
    logic [AW-1:0]     acq_q;
    logic              locked_q;
    logic              wrap_q;
    logic              err_q;
    logic [ERR_W-1:0]  err_cnt_q;

    logic code_legal;
    logic lock_err;
    logic wrap_inc;

    assign code_legal = legal_next(prev_q, code_in);
    // An illegal sample while locked is the only thing that raises err
    assign lock_err   = en && (state_q == LOCK) && !code_legal;
    assign wrap_inc   = en && (state_q == LOCK) && code_legal && (prev_q == C2);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            prev_q    <= C0;
            acq_q     <= '0;
            locked_q  <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (en) begin
                prev_q <= code_in;
                unique case (state_q)
                    IDLE: begin
                        acq_q   <= '0;
                        state_q <= (code_in == CX) ? IDLE : ACQ;
                    end
                    ACQ: begin
                        if (code_legal) begin
                            // acq_q counts completed legal steps minus one here
                            if (acq_q == AW'(LOCK_CYC - 1)) begin
                                state_q  <= LOCK;
                                locked_q <= 1'b1;
                                acq_q    <= '0;
                            end else begin
                                acq_q <= acq_q + 1'b1;
                            end
                        end else begin
                            acq_q <= '0;
                            if (code_in == CX) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    LOCK: begin
                        if (code_legal) begin
                            wrap_q <= (prev_q == C2);
                        end else begin
                            err_q     <= 1'b1;
                            locked_q  <= 1'b0;
                            acq_q     <= '0;
                            state_q   <= (code_in == CX) ? IDLE : ACQ;
                            if (err_cnt_q != {ERR_W{1'b1}}) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                        acq_q    <= '0;
                    end
                endcase
            end
        end
    end

    modn_wrap_counter #(
        .MOD (MOD)
    ) u_wrap_cnt (
        .clk (clk),
        .res (res),
        .clr (lock_err),
        .inc (wrap_inc),
        .cnt (cnt),
        .tc  (tc)
    );

`ifdef MOD3MON_STICKY_ERR_EN
    logic err_flag_q;

    // Set wins over clear so an error in the clearing cycle is never lost
    always_ff @(posedge clk) begin
        if (res) begin
            err_flag_q <= 1'b0;
        end else if (lock_err) begin
            err_flag_q <= 1'b1;
        end else if (err_clr) begin
            err_flag_q <= 1'b0;
        end
    end

    assign err_flag = err_flag_q;
`endif

    assign locked  = locked_q;
    assign wrap    = wrap_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mod3_seq_monitor.sv
// tb/tb_mod3_seq_monitor.sv - self-checking bench for mod3_seq_monitor against a behavioural model
module tb_mod3_seq_monitor;

    localparam int MOD      = 4;
    localparam int LOCK_CYC = 3;
    localparam int ERR_W    = 2;
    localparam int CW       = $clog2(MOD);
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             en = 1'b0;
    logic [1:0]       code_in = 2'b00;
    logic             locked;
    logic             wrap;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
`ifdef MOD3MON_STICKY_ERR_EN
    logic             err_clr = 1'b0;
    logic             err_flag;
`endif

    always #5 clk = ~clk;

    mod3_seq_monitor #(
        .MOD      (MOD),
        .LOCK_CYC (LOCK_CYC),
        .ERR_W    (ERR_W)
    ) dut (
        .clk      (clk),
        .res      (res),
        .en       (en),
        .code_in  (code_in),
        .locked   (locked),
        .wrap     (wrap),
        .cnt      (cnt),
        .tc       (tc),
        .err      (err),
`ifdef MOD3MON_STICKY_ERR_EN
        .err_clr  (err_clr),
        .err_flag (err_flag),
`endif
        .err_cnt  (err_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: mode 0 = waiting for first code, 1 = acquiring, 2 = locked
    int m_mode = 0;
    int m_prev = 0;
    int m_acq  = 0;
    int m_wc   = 0;
    int m_ec   = 0;
    int m_wrap = 0;
    int m_tc   = 0;
    int m_err  = 0;
    int m_flag = 0;
    int up     = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int r, input int e, input int c, input int clr);
        int legal;
        if (r != 0) begin
            m_mode = 0; m_prev = 0; m_acq = 0; m_wc = 0; m_ec = 0;
            m_wrap = 0; m_tc = 0; m_err = 0; m_flag = 0;
            return;
        end
        m_wrap = 0; m_tc = 0; m_err = 0;
        if (e != 0) begin
            legal = (m_prev != 3) && (c == (m_prev + 1) % 3);
            if (m_mode == 0) begin
                m_mode = (c == 3) ? 0 : 1;
                m_acq  = 0;
            end else if (m_mode == 1) begin
                if (legal != 0) begin
                    m_acq++;
                    if (m_acq == LOCK_CYC) begin
                        m_mode = 2;
                        m_acq  = 0;
                    end
                end else begin
                    m_acq = 0;
                    if (c == 3) m_mode = 0;
                end
            end else begin
                if (legal != 0) begin
                    if (m_prev == 2) begin
                        m_wrap = 1;
                        m_wc   = (m_wc + 1) % MOD;
                        m_tc   = (m_wc == 0);
                    end
                end else begin
                    m_err  = 1;
                    m_ec   = (m_ec < ERR_MAX) ? m_ec + 1 : ERR_MAX;
                    m_wc   = 0;
                    m_acq  = 0;
                    m_mode = (c == 3) ? 0 : 1;
                end
            end
            m_prev = c;
        end
        if (m_err != 0)      m_flag = 1;
        else if (clr != 0)   m_flag = 0;
    endtask

    task automatic check_all();
        check_val("locked",  32'(locked),  32'(m_mode == 2));
        check_val("wrap",    32'(wrap),    32'(m_wrap));
        check_val("cnt",     32'(cnt),     32'(m_wc));
        check_val("tc",      32'(tc),      32'(m_tc));
        check_val("err",     32'(err),     32'(m_err));
        check_val("err_cnt", 32'(err_cnt), 32'(m_ec));
`ifdef MOD3MON_STICKY_ERR_EN
        check_val("err_flag", 32'(err_flag), 32'(m_flag));
`endif
    endtask

    task automatic cyc(input int r, input int e, input int c, input int clr);
        @(negedge clk);
        res     = (r != 0);
        en      = (e != 0);
        code_in = 2'(c);
`ifdef MOD3MON_STICKY_ERR_EN
        err_clr = (clr != 0);
`endif
        @(posedge clk);
        model_step(r, e, c, clr);
        #1;
        check_all();
    endtask

    task automatic clean();
        cyc(0, 1, up, 0);
        up = (up + 1) % 3;
    endtask

    // Advance the clean stream until locked with the next code to send equal to want_up
    task automatic run_to(input int want_up, input int budget, input string tag);
        int b;
        b = budget;
        while (!(m_mode == 2 && up == want_up) && b > 0) begin
            clean();
            b--;
        end
        if (b == 0) check_val(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int b;
        int held;

        // Reset with random codes
        for (int i = 0; i < 2; i++) cyc(1, $urandom_range(0, 1), $urandom_range(0, 3), 0);
        check_val("reset_locked", 32'(locked), 32'd0);

        // Clean stream from 00: load + 3 legal transitions before lock
        up = 0;
        for (int i = 0; i < 3; i++) clean();
        check_val("not_locked_early", 32'(locked), 32'd0);
        clean();
        check_val("locked_after_3_legal", 32'(locked), 32'd1);
        for (int i = 0; i < 26; i++) clean();

        // Inject 01 -> 11 -> 00 while locked
        run_to(1, 10, "budget_inject");
        cyc(0, 1, 1, 0);
        cyc(0, 1, 3, 0);
        check_val("inject_err", 32'(err), 32'd1);
        check_val("inject_err_cnt", 32'(err_cnt), 32'd1);
        check_val("inject_unlock", 32'(locked), 32'd0);
        up = 0;
        for (int i = 0; i < 3; i++) clean();
        check_val("relock_not_early", 32'(locked), 32'd0);
        clean();
        check_val("relock", 32'(locked), 32'd1);
        for (int i = 0; i < 6; i++) clean();

        // en=0 for 5 cycles with code frozen at 01
        run_to(2, 10, "budget_hold");
        held = m_wc;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        check_val("hold_cnt", 32'(cnt), 32'(held));
        for (int i = 0; i < 9; i++) clean();

        // Five stalls on 10 across relocks
        for (int k = 0; k < 5; k++) begin
            run_to(0, 20, "budget_stall");
            cyc(0, 1, 2, 0);
            check_val("stall_err", 32'(err), 32'd1);
        end
        check_val("err_cnt_sat", 32'(err_cnt), 32'(ERR_MAX));

        // Reset mid-lock with cnt=2
        b = 40;
        while (!(m_mode == 2 && m_wc == 2) && b > 0) begin
            clean();
            b--;
        end
        if (b == 0) check_val("budget_cnt2", 32'd0, 32'd1);
        cyc(1, 1, up, 0);
        check_val("midlock_reset_locked", 32'(locked), 32'd0);
        check_val("midlock_reset_cnt", 32'(cnt), 32'd0);
`ifdef MOD3MON_STICKY_ERR_EN
        check_val("midlock_reset_flag", 32'(err_flag), 32'd0);
        up = 0;
        run_to(1, 20, "budget_sticky");
        cyc(0, 1, 3, 1);
        check_val("flag_set_wins", 32'(err_flag), 32'd1);
        cyc(0, 1, 0, 1);
        check_val("flag_clear", 32'(err_flag), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            int e;
            int c;
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) < 8) begin
                c = up;
                if (e != 0) up = (up + 1) % 3;
            end else begin
                c = $urandom_range(0, 3);
            end
            cyc(r, e, c, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
